// File: rtl/dmem_responder.sv
// Data-memory responder: services one load/store at a time on a word array.
// Word-crossing accesses are split into two consecutive word cycles.
module dmem_responder #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int WA_W  = ADDR_W - 2;
    localparam int DEPTH = 1 << WA_W;

    typedef enum logic [1:0] {
        IDLE,
        ACC0,
        ACC1,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [WA_W-1:0]   w0_q, w0_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       buf0_q, buf0_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [31:0]       mem [DEPTH];

    logic              legal_in;
    logic [2:0]        size_b;
    logic [3:0]        mask;
    logic              split;
    logic [WA_W-1:0]   w1;
    logic [63:0]       wvec;
    logic [7:0]        be;
    logic [WA_W-1:0]   rd_idx;
    logic [31:0]       rd_word;

    logic              wr_en;
    logic [WA_W-1:0]   wr_idx;
    logic [31:0]       wr_data;
    logic [3:0]        wr_be;

    function automatic logic [31:0] load_fmt(
        input logic [2:0]  f3,
        input logic [63:0] vec,
        input logic [1:0]  off
    );
        logic [31:0] raw;
        raw = 32'(vec >> {off, 3'b000});
        unique case (f3)
            3'b000:  load_fmt = {{24{raw[7]}}, raw[7:0]};
            3'b001:  load_fmt = {{16{raw[15]}}, raw[15:0]};
            3'b100:  load_fmt = {24'b0, raw[7:0]};
            3'b101:  load_fmt = {16'b0, raw[15:0]};
            default: load_fmt = raw;
        endcase
    endfunction

    // Loads reject 011/110/111; stores accept only 000/001/010.
    always_comb begin
        legal_in = 1'b0;
        if (req_we) begin
            legal_in = !req_funct3[2] && (req_funct3[1:0] != 2'b11);
        end else begin
            legal_in = (req_funct3[1:0] != 2'b11)
                    && !(req_funct3[2] && req_funct3[1]);
        end
    end

    always_comb begin
        size_b = 3'd4;
        mask   = 4'b1111;
        unique case (f3_q[1:0])
            2'b00: begin
                size_b = 3'd1;
                mask   = 4'b0001;
            end
            2'b01: begin
                size_b = 3'd2;
                mask   = 4'b0011;
            end
            default: begin
                size_b = 3'd4;
                mask   = 4'b1111;
            end
        endcase
    end

    assign split   = ({1'b0, off_q} + size_b) > 3'd4;
    assign w1      = w0_q + WA_W'(1);
    assign wvec    = {32'b0, wdata_q} << {off_q, 3'b000};
    assign be      = 8'({4'b0000, mask} << off_q);
    assign rd_idx  = (state_q == ACC1) ? w1 : w0_q;
    assign rd_word = mem[rd_idx];

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        w0_d    = w0_q;
        wdata_d = wdata_q;
        buf0_d  = buf0_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        wr_idx  = w0_q;
        wr_data = wvec[31:0];
        wr_be   = be[3:0];
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    off_d   = req_addr[1:0];
                    w0_d    = req_addr[ADDR_W-1:2];
                    wdata_d = req_wdata;
                    if (legal_in) begin
                        state_d = ACC0;
                    end else begin
                        state_d = RESP;
                        rdata_d = 32'b0;
                        err_d   = 1'b1;
                    end
                end
            end
            ACC0: begin
                wr_en  = we_q;
                buf0_d = rd_word;
                if (split) begin
                    state_d = ACC1;
                end else begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = we_q ? 32'b0
                            : load_fmt(f3_q, {32'b0, rd_word}, off_q);
                end
            end
            ACC1: begin
                wr_en   = we_q;
                wr_idx  = w1;
                wr_data = wvec[63:32];
                wr_be   = be[7:4];
                state_d = RESP;
                err_d   = 1'b0;
                rdata_d = we_q ? 32'b0
                        : load_fmt(f3_q, {rd_word, buf0_q}, off_q);
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b0;
            off_q   <= 2'b0;
            w0_q    <= '0;
            wdata_q <= 32'b0;
            buf0_q  <= 32'b0;
            rdata_q <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            w0_q    <= w0_d;
            wdata_q <= wdata_d;
            buf0_q  <= buf0_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic
// checked against a byte-addressed reference memory.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [15:0] req_addr = 16'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [7:0] mdl [0:65535];

    dmem_responder #(.ADDR_W(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_funct3(req_funct3),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit mlegal(input logic we, input logic [2:0] f3);
        if (we) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2)
            || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic int mlat(input logic we, input logic [2:0] f3,
                                input logic [15:0] a);
        int off;
        off = int'(a % 4);
        if (!mlegal(we, f3)) return 1;
        if (off + nbytes(f3) > 4) return 3;
        return 2;
    endfunction

    function automatic logic [31:0] mload(input logic [15:0] a,
                                          input logic [2:0] f3);
        int n;
        logic [31:0] v;
        n = nbytes(f3);
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[16'(a + i)];
        if (!f3[2] && n < 4 && v[8*n-1])
            for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic mstore(input logic [15:0] a, input logic [2:0] f3,
                          input logic [31:0] d);
        for (int i = 0; i < nbytes(f3); i++) mdl[16'(a + i)] = d[8*i +: 8];
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [15:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic e,
                          output int lat, output int acc);
        int n;
        rd = 32'h0; e = 1'b0; lat = 0; acc = 0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL req_accept_timeout: req_ready=%b required 1",
                     req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        acc = cyc;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = 16'($urandom); req_wdata = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        tests++;
        if (rsp_valid !== 1'b1) begin
            fails++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
            return;
        end
        rd = rsp_rdata; e = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests += 4;
        if (req_ready !== 1'b1) begin
            fails++; $display("FAIL reset_req_ready: got %b want 1", req_ready);
        end
        if (rsp_valid !== 1'b0) begin
            fails++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid);
        end
        if (rsp_rdata !== 32'h0) begin
            fails++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata);
        end
        if (rsp_err !== 1'b0) begin
            fails++; $display("FAIL reset_err: got %b want 0", rsp_err);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_aligned();
        logic [31:0] rd; logic e; int lat, ac;
        do_req(1'b1, 3'b010, 16'h0100, 32'hDEADBEEF, rd, e, lat, ac);
        mstore(16'h0100, 3'b010, 32'hDEADBEEF);
        tests++;
        if (lat !== 2 || rd !== 32'h0 || e !== 1'b0) begin
            fails++;
            $display("FAIL sw_aligned: lat=%0d rd=%h err=%b want 2/0/0",
                     lat, rd, e);
        end
        do_req(1'b0, 3'b010, 16'h0100, $urandom, rd, e, lat, ac);
        tests++;
        if (lat !== 2 || rd !== 32'hDEADBEEF || e !== 1'b0) begin
            fails++;
            $display("FAIL lw_aligned: lat=%0d rd=%h err=%b want 2/deadbeef/0",
                     lat, rd, e);
        end
    endtask

    task automatic test_split_half();
        logic [31:0] rd, p; logic e; int lat, ac;
        p = $urandom;
        do_req(1'b1, 3'b010, 16'h0000, p, rd, e, lat, ac);
        mstore(16'h0000, 3'b010, p);
        p = $urandom;
        do_req(1'b1, 3'b010, 16'h0004, p, rd, e, lat, ac);
        mstore(16'h0004, 3'b010, p);
        do_req(1'b1, 3'b001, 16'h0003, 32'h00008001, rd, e, lat, ac);
        mstore(16'h0003, 3'b001, 32'h00008001);
        tests++;
        if (lat !== 3 || rd !== 32'h0 || e !== 1'b0) begin
            fails++;
            $display("FAIL sh_split: lat=%0d rd=%h err=%b want 3/0/0",
                     lat, rd, e);
        end
        do_req(1'b0, 3'b001, 16'h0003, 32'h0, rd, e, lat, ac);
        tests++;
        if (lat !== 3 || rd !== 32'hFFFF8001) begin
            fails++;
            $display("FAIL lh_split: lat=%0d rd=%h want 3/ffff8001", lat, rd);
        end
        do_req(1'b0, 3'b101, 16'h0003, 32'h0, rd, e, lat, ac);
        tests++;
        if (rd !== 32'h00008001) begin
            fails++; $display("FAIL lhu_split: got %h want 00008001", rd);
        end
        do_req(1'b0, 3'b010, 16'h0004, 32'h0, rd, e, lat, ac);
        tests++;
        if (rd[7:0] !== 8'h80 || rd !== mload(16'h0004, 3'b010)) begin
            fails++;
            $display("FAIL lw_after_sh: got %h want %h", rd,
                     mload(16'h0004, 3'b010));
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic e; int lat, ac;
        do_req(1'b1, 3'b010, 16'h0004, 32'h11223344, rd, e, lat, ac);
        mstore(16'h0004, 3'b010, 32'h11223344);
        do_req(1'b1, 3'b000, 16'h0006, 32'h5A5A5A80, rd, e, lat, ac);
        mstore(16'h0006, 3'b000, 32'h5A5A5A80);
        do_req(1'b0, 3'b010, 16'h0004, 32'h0, rd, e, lat, ac);
        tests++;
        if (rd !== 32'h11803344) begin
            fails++; $display("FAIL sb_lanes: got %h want 11803344", rd);
        end
        do_req(1'b0, 3'b000, 16'h0006, 32'h0, rd, e, lat, ac);
        tests++;
        if (rd !== 32'hFFFFFF80) begin
            fails++; $display("FAIL lb_sext: got %h want ffffff80", rd);
        end
        do_req(1'b0, 3'b100, 16'h0006, 32'h0, rd, e, lat, ac);
        tests++;
        if (rd !== 32'h00000080) begin
            fails++; $display("FAIL lbu_zext: got %h want 00000080", rd);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic e; int lat, ac;
        logic [15:0] adr [4];
        logic [7:0]  byt [4];
        adr[0] = 16'hFFFE; adr[1] = 16'hFFFF; adr[2] = 16'h0000; adr[3] = 16'h0001;
        byt[0] = 8'hDD; byt[1] = 8'hCC; byt[2] = 8'hBB; byt[3] = 8'hAA;
        do_req(1'b1, 3'b010, 16'hFFFE, 32'hAABBCCDD, rd, e, lat, ac);
        mstore(16'hFFFE, 3'b010, 32'hAABBCCDD);
        tests++;
        if (lat !== 3 || e !== 1'b0) begin
            fails++; $display("FAIL sw_wrap: lat=%0d err=%b want 3/0", lat, e);
        end
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 3'b100, adr[i], 32'h0, rd, e, lat, ac);
            tests++;
            if (rd !== {24'h0, byt[i]}) begin
                fails++;
                $display("FAIL lbu_wrap_%h: got %h want %h", adr[i], rd, byt[i]);
            end
        end
        do_req(1'b0, 3'b010, 16'hFFFE, 32'h0, rd, e, lat, ac);
        tests++;
        if (rd !== 32'hAABBCCDD || lat !== 3) begin
            fails++;
            $display("FAIL lw_wrap: got %h lat=%0d want aabbccdd/3", rd, lat);
        end
    endtask

    task automatic test_error();
        logic [31:0] rd; logic e; int lat, ac;
        do_req(1'b0, 3'b011, 16'h0100, 32'h0, rd, e, lat, ac);
        tests++;
        if (e !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
            fails++;
            $display("FAIL err_load011: err=%b rd=%h lat=%0d want 1/0/1",
                     e, rd, lat);
        end
        do_req(1'b1, 3'b100, 16'h0100, 32'h01234567, rd, e, lat, ac);
        tests++;
        if (e !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
            fails++;
            $display("FAIL err_store100: err=%b rd=%h lat=%0d want 1/0/1",
                     e, rd, lat);
        end
        do_req(1'b0, 3'b010, 16'h0100, 32'h0, rd, e, lat, ac);
        tests++;
        if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
            fails++;
            $display("FAIL err_no_write: got %h err=%b want deadbeef/0", rd, e);
        end
    endtask

    task automatic test_backpressure();
        int n;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 16'h0100; req_wdata = 32'h0;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++; $display("FAIL bp_idle_ready: got %b want 1", req_ready);
        end
        @(posedge clk); #1;
        req_we = 1'b1; req_wdata = 32'h0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF
                || req_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold_%0d: valid=%b rd=%h ready=%b want 1/deadbeef/0",
                         i, rsp_valid, rsp_rdata, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: valid=%b ready=%b want 0/1",
                     rsp_valid, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, d; logic e; int lat, a1, a2;
        d = $urandom;
        do_req(1'b1, 3'b010, 16'h0020, d, rd, e, lat, a1);
        mstore(16'h0020, 3'b010, d);
        do_req(1'b0, 3'b010, 16'h0020, 32'h0, rd, e, lat, a2);
        tests++;
        if (a2 - a1 !== 3 || rd !== d) begin
            fails++;
            $display("FAIL b2b_aligned: gap=%0d rd=%h want 3/%h", a2 - a1, rd, d);
        end
        d = $urandom;
        do_req(1'b1, 3'b010, 16'h0025, d, rd, e, lat, a1);
        mstore(16'h0025, 3'b010, d);
        do_req(1'b0, 3'b010, 16'h0025, 32'h0, rd, e, lat, a2);
        tests++;
        if (a2 - a1 !== 4 || rd !== d) begin
            fails++;
            $display("FAIL b2b_split: gap=%0d rd=%h want 4/%h", a2 - a1, rd, d);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd; logic e; int lat, ac;
        do_req(1'b1, 3'b010, 16'h0004, 32'h12345678, rd, e, lat, ac);
        mstore(16'h0004, 3'b010, 32'h12345678);
        do_req(1'b1, 3'b010, 16'h0008, 32'h9ABCDEF0, rd, e, lat, ac);
        mstore(16'h0008, 3'b010, 32'h9ABCDEF0);
        do_req(1'b0, 3'b010, 16'h0004, 32'h0, rd, e, lat, ac);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 16'h0007; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        tests++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0
            || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            fails++;
            $display("FAIL midop_async_reset: ready=%b valid=%b rd=%h err=%b want 1/0/0/0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++; $display("FAIL midop_release_ready: got %b want 1", req_ready);
        end
        do_req(1'b0, 3'b010, 16'h0004, 32'h0, rd, e, lat, ac);
        tests++;
        if (rd !== mload(16'h0004, 3'b010) || lat !== 2 || e !== 1'b0) begin
            fails++;
            $display("FAIL midop_lw4: got %h lat=%0d want %h/2",
                     rd, lat, mload(16'h0004, 3'b010));
        end
        do_req(1'b0, 3'b010, 16'h0008, 32'h0, rd, e, lat, ac);
        tests++;
        if (rd !== mload(16'h0008, 3'b010)) begin
            fails++;
            $display("FAIL midop_lw8: got %h want %h", rd,
                     mload(16'h0008, 3'b010));
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, wd, exp_rd; logic e, we; int lat, ac, a, exp_lat;
        logic [2:0] f3; logic [15:0] adr;
        for (int i = 0; i < 20; i++) begin
            wd = $urandom;
            do_req(1'b1, 3'b010, 16'(4*i), wd, rd, e, lat, ac);
            mstore(16'(4*i), 3'b010, wd);
        end
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            do_req(1'b1, 3'b010, 16'(16'hFFC0 + 4*i), wd, rd, e, lat, ac);
            mstore(16'(16'hFFC0 + 4*i), 3'b010, wd);
        end
        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom);
            f3 = 3'($urandom_range(0, 7));
            a = $urandom_range(0, 127);
            adr = (a < 64) ? 16'(a) : 16'(16'hFFC0 + a - 64);
            wd = $urandom;
            exp_lat = mlat(we, f3, adr);
            exp_rd = (!mlegal(we, f3) || we) ? 32'h0 : mload(adr, f3);
            do_req(we, f3, adr, wd, rd, e, lat, ac);
            if (we && mlegal(we, f3)) mstore(adr, f3, wd);
            tests++;
            if (rd !== exp_rd || e !== !mlegal(we, f3) || lat !== exp_lat) begin
                fails++;
                $display("FAIL rand_%0d we=%b f3=%0d a=%h: rd=%h err=%b lat=%0d want %h/%b/%0d",
                         i, we, f3, adr, rd, e, lat, exp_rd,
                         !mlegal(we, f3), exp_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_split_half();
        test_byte_lanes();
        test_wrap();
        test_error();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
